// File: rtl/nexys_input_scanner_pkg.sv
// Shared constants for the Nexys A7 board input path: switch/button counts,
// button bit positions and the default debounce interval.
package swervolf_io_pkg;

  localparam int N_SW  = 16;
  localparam int N_BTN = 5;
  localparam int N_IN  = N_SW + N_BTN;

  // 10 ms at a 100 MHz core clock
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

  localparam int BTN_C = 16;
  localparam int BTN_U = 17;
  localparam int BTN_L = 18;
  localparam int BTN_R = 19;
  localparam int BTN_D = 20;

  // Counter width for a debounce interval; never narrower than one bit.
  function automatic int deb_cnt_w(input int cycles);
    return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/nexys_input_scanner_if.sv
// Signal bundle between board-side inputs/CPU controls and the input scanner.
interface nexys_input_scanner_if #(
  parameter int N_IN = 21
);
  // No handshake: every output is a level that is valid on every clk_core cycle;
  // i_clr is a single-cycle pulse and i_clr_mask is only looked at while it is high.
  logic [N_IN-1:0] i_raw;
  logic            i_clr;
  logic [N_IN-1:0] i_clr_mask;
  logic [N_IN-1:0] i_irq_mask;
  logic [N_IN-1:0] o_level;
  logic [N_IN-1:0] o_rise;
  logic [N_IN-1:0] o_fall;
  logic            o_irq;

  modport master (
    output i_raw, i_clr, i_clr_mask, i_irq_mask,
    input  o_level, o_rise, o_fall, o_irq
  );

  modport slave (
    input  i_raw, i_clr, i_clr_mask, i_irq_mask,
    output o_level, o_rise, o_fall, o_irq
  );
endinterface

// File: rtl/nexys_input_scanner_debounce.sv
// One-bit synchronizer + debouncer: accepts a new level after it has been
// stable for DEBOUNCE_CYCLES samples and pulses accept_rise/accept_fall once.
module io_debounce_bit
  import swervolf_io_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic RESET_BIT       = 1'b0
) (
  input  logic clk_core,
  input  logic rstn,
  input  logic raw,
  output logic level,
  output logic accept_rise,
  output logic accept_fall
);

  localparam int            CW       = deb_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          accept;

  // The counter is cleared on acceptance, so it never needs to wrap.
  assign accept      = (s2 != level) && (cnt == CNT_LAST);
  assign accept_rise = accept & s2;
  assign accept_fall = accept & ~s2;

  always_ff @(posedge clk_core or negedge rstn) begin
    if (!rstn) begin
      s1    <= RESET_BIT;
      s2    <= RESET_BIT;
      level <= RESET_BIT;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/nexys_input_scanner.sv
// Board input scanner: per-bit debounce, sticky rise/fall event capture with
// masked clear, and a registered maskable level interrupt.
module nexys_input_scanner
  import swervolf_io_pkg::*;
#(
  parameter int              N_IN            = swervolf_io_pkg::N_IN,
  parameter int              DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [N_IN-1:0] RESET_LEVEL     = '0
) (
  input  logic                  clk_core,
  input  logic                  rstn,
  nexys_input_scanner_if.slave  bus
);

  logic [N_IN-1:0] level;
  logic [N_IN-1:0] acc_rise;
  logic [N_IN-1:0] acc_fall;
  logic [N_IN-1:0] rise_q;
  logic [N_IN-1:0] fall_q;
  logic [N_IN-1:0] clr_vec;
  logic            irq_q;

  for (genvar g = 0; g < N_IN; g++) begin : g_bit
    io_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_BIT       (RESET_LEVEL[g])
    ) u_deb (
      .clk_core    (clk_core),
      .rstn        (rstn),
      .raw         (bus.i_raw[g]),
      .level       (level[g]),
      .accept_rise (acc_rise[g]),
      .accept_fall (acc_fall[g])
    );
  end

  assign clr_vec = bus.i_clr ? bus.i_clr_mask : '0;

  // A new event is OR-ed in after the clear, so a coincident set wins.
  always_ff @(posedge clk_core or negedge rstn) begin
    if (!rstn) begin
      rise_q <= '0;
      fall_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      rise_q <= (rise_q & ~clr_vec) | acc_rise;
      fall_q <= (fall_q & ~clr_vec) | acc_fall;
      irq_q  <= |((rise_q | fall_q) & bus.i_irq_mask);
    end
  end

  assign bus.o_level = level;
  assign bus.o_rise  = rise_q;
  assign bus.o_fall  = fall_q;
  assign bus.o_irq   = irq_q;

endmodule
